// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: word-organised RAM behind AW/W/B and AR/R channels, with one
// outstanding transaction per direction, FIXED/INCR/WRAP bursts, strobes and SLVERR.
module axi_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] BYTES = (ADDR_W+1)'(MEM_DEPTH * NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic burst_bad(input logic [2:0] size, input logic [3:0] len,
                                       input logic [1:0] burst);
        return (size > 3'(OFF)) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [3:0] len,
                                                   input logic [1:0] burst);
        logic [ADDR_W-1:0] nb, wb;
        nb = ADDR_W'(1) << size;
        wb = nb * (ADDR_W'(len) + ADDR_W'(1));
        case (burst)
            2'b01:   return a + nb;
            2'b10:   return (a & ~(wb - ADDR_W'(1))) | ((a + nb) & (wb - ADDR_W'(1)));
            default: return a;
        endcase
    endfunction

    // ---------------- write path ----------------
    wstate_t           w_state, w_state_n;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_bad, w_acc;
    logic              aw_hs, w_hs, b_hs, w_last_beat, w_beat_err;

    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign b_hs        = bvalid & bready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = w_bad | oor(w_addr) | (wid != w_id) | (wlast != w_last_beat);

    always_comb begin
        w_state_n = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_n = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_n = W_RESP;
            W_RESP:  if (b_hs) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

    // Ready/valid are registered copies of the next state, so they rise one edge after reset.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_acc   <= 1'b0;
        end else begin
            w_state <= w_state_n;
            awready <= (w_state_n == W_IDLE);
            wready  <= (w_state_n == W_DATA);
            bvalid  <= (w_state_n == W_RESP);
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_bad   <= burst_bad(awsize, awlen, awburst);
                w_acc   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                w_cnt  <= w_cnt + 4'd1;
                w_acc  <= w_acc | w_beat_err;
                if (w_last_beat) begin
                    bid   <= w_id;
                    bresp <= {w_acc | w_beat_err, 1'b0};
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_beat_err)
            for (int b = 0; b < NB; b++)
                if (wstrb[b]) mem[idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
    end

    // ---------------- read path ----------------
    rstate_t           r_state, r_state_n;
    logic [ADDR_W-1:0] r_addr, f_addr;
    logic [3:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_bad, f_err, ar_hs, r_hs, fetch;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign fetch = ar_hs | (r_hs & ~rlast);

    always_comb begin
        r_state_n = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_n = R_DATA;
            R_DATA:  if (r_hs && rlast) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    // The fetch address is the new burst start in idle, otherwise the next beat address.
    always_comb begin
        f_addr = araddr;
        f_err  = burst_bad(arsize, arlen, arburst) | oor(araddr);
        if (r_state == R_DATA) begin
            f_addr = next_addr(r_addr, r_size, r_len, r_burst);
            f_err  = r_bad | oor(f_addr);
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= r_state_n;
            arready <= (r_state_n == R_IDLE);
            rvalid  <= (r_state_n == R_DATA);
            if (ar_hs) begin
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
                r_bad   <= burst_bad(arsize, arlen, arburst);
                rid     <= arid;
                rlast   <= (arlen == 4'd0);
            end else if (r_hs && !rlast) begin
                r_addr <= f_addr;
                r_cnt  <= r_cnt + 4'd1;
                rlast  <= (r_cnt + 4'd1 == r_len);
            end
            // Non-blocking read of mem: a same-edge write to this word is not yet visible.
            if (fetch) begin
                rdata <= f_err ? '0 : mem[idx(f_addr)];
                rresp <= f_err ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised bench for axi_slave_mem: byte-array memory model, expected-beat queues
// and a negedge monitor that checks every B/R handshake and stall.
module tb_axi_slave_mem;
    localparam int BYTES = 1024;

    logic        aclk = 1'b0;
    logic        reset;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(256)) dut (
        .aclk(aclk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int compared = 0, mismatched = 0;
    logic [7:0] mm [BYTES];
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];
    logic [31:0] got_d[$];
    logic [1:0]  got_rr[$];
    logic        got_l[$];
    int          got_cyc[$];
    logic [3:0]  last_bid;
    logic [1:0]  last_bresp;
    int b_seen = 0, r_seen = 0, cyc = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          wid_v [16];
    bit          wl_v [16];
    bit          rpat [3] = '{1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL timeout_%s: event not seen within cycle budget", name);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return awready;
            1: return wready;
            2: return arready;
            3: return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string nm);
        int t = 0;
        @(negedge aclk);
        while (!sig(sel) && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 200) timeout_fail(nm);
    endtask

    // ---------------- reference model ----------------
    function automatic bit bad_burst(input int size, input int len, input int burst);
        return ((1 << size) > 4) || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int beat_addr(input int a, input int size, input int len,
                                     input int burst, input int i);
        int nb = 1 << size;
        int w  = nb * (len + 1);
        case (burst)
            1: return a + i * nb;
            2: return (a / w) * w + ((a + i * nb) % w);
            default: return a;
        endcase
    endfunction

    task automatic prep_w(input int id, input int len);
        for (int i = 0; i < 16; i++) begin
            wid_v[i] = id;
            wl_v[i]  = (i == len);
        end
    endtask

    // ---------------- master tasks ----------------
    task automatic do_write(input int id, input int a, input int len, input int size,
                            input int burst, input int bdelay);
        bit    bad = bad_burst(size, len, burst);
        bit    acc = 0;
        int    tgt, t;
        bexp_t eb;
        for (int i = 0; i <= len; i++) begin
            int ba = beat_addr(a, size, len, burst, i);
            bit e  = bad || ba >= BYTES || wid_v[i] != id || wl_v[i] != (i == len);
            acc = acc | e;
            if (!e)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mm[(ba / 4) * 4 + b] = wd[i][8*b +: 8];
        end
        eb.id = 4'(id);
        eb.resp = acc ? 2'b10 : 2'b00;
        exp_b.push_back(eb);

        awid = 4'(id); awaddr = a; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        wait_sig(0, "awready");
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom % 4 == 0) begin @(posedge aclk); #1; end
            wdata = wd[i]; wstrb = ws[i]; wid = 4'(wid_v[i]); wlast = wl_v[i];
            wvalid = 1'b1;
            wait_sig(1, "wready");
            @(posedge aclk); #1 wvalid = 1'b0;
        end
        wait_sig(3, "bvalid");
        @(posedge aclk); #1;
        for (int k = 0; k < bdelay; k++) begin
            chk("b_hold_bvalid", bvalid, 1);
            chk("b_hold_awready", awready, 0);
            @(posedge aclk); #1;
        end
        tgt = b_seen + 1;
        bready = 1'b1;
        t = 0;
        while (b_seen != tgt && t < 50) begin @(posedge aclk); #1; t++; end
        if (t >= 50) timeout_fail("b_handshake");
        bready = 1'b0;
    endtask

    // mode 0: rready held high, 1: random rready, 2: rready follows rpat then high
    task automatic do_read(input int id, input int a, input int len, input int size,
                           input int burst, input int mode);
        bit     bad = bad_burst(size, len, burst);
        int     tgt, t = 0, k = 0;
        rbeat_t r;
        for (int i = 0; i <= len; i++) begin
            int ba = beat_addr(a, size, len, burst, i);
            bit e  = bad || ba >= BYTES;
            int w  = (ba / 4) * 4;
            r.id = 4'(id);
            r.last = (i == len);
            r.resp = e ? 2'b10 : 2'b00;
            r.data = '0;
            if (!e) r.data = {mm[w+3], mm[w+2], mm[w+1], mm[w]};
            exp_r.push_back(r);
        end
        got_d.delete(); got_rr.delete(); got_l.delete(); got_cyc.delete();
        arid = 4'(id); araddr = a; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        wait_sig(2, "arready");
        @(posedge aclk); #1 arvalid = 1'b0;
        rready = (mode == 0) ? 1'b1 : (mode == 2) ? rpat[0] : 1'($urandom % 2);
        tgt = r_seen + len + 1;
        while (r_seen != tgt && t < 400) begin
            @(posedge aclk); #1;
            t++; k++;
            rready = (mode == 0) ? 1'b1 : (mode == 2) ? (k < 3 ? rpat[k] : 1'b1) : 1'($urandom % 2);
        end
        if (t >= 400) timeout_fail("r_burst");
        rready = 1'b0;
        if (mode == 0 && got_cyc.size() == len + 1)
            chk("no_bubble", got_cyc[len] - got_cyc[0], len);
    endtask

    // ---------------- monitor ----------------
    bit          r_hold = 0, b_hold = 0;
    logic [38:0] hr;
    logic [5:0]  hb;
    rbeat_t      er;
    bexp_t       ebm;

    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (reset) begin
            r_hold = 0;
            b_hold = 0;
        end else begin
            if (bvalid) begin
                chk("awready_during_b", awready, 0);
                if (b_hold) chk("b_stable", {bid, bresp}, hb);
                if (bready) begin
                    if (exp_b.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL b_unexpected: got bid %0h, no response expected", bid);
                    end else begin
                        ebm = exp_b.pop_front();
                        chk("bid", bid, ebm.id);
                        chk("bresp", bresp, ebm.resp);
                    end
                    last_bid = bid; last_bresp = bresp;
                    b_seen++;
                    b_hold = 0;
                end else begin
                    b_hold = 1;
                    hb = {bid, bresp};
                end
            end else if (b_hold) begin
                chk("bvalid_held", bvalid, 1);
                b_hold = 0;
            end
            if (rvalid) begin
                if (r_hold) chk("r_stable", {rid, rdata, rresp, rlast}, hr);
                if (rready) begin
                    if (exp_r.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL r_unexpected: got rdata %0h, no beat expected", rdata);
                    end else begin
                        er = exp_r.pop_front();
                        chk("rid", rid, er.id);
                        chk("rdata", rdata, er.data);
                        chk("rresp", rresp, er.resp);
                        chk("rlast", rlast, er.last);
                    end
                    got_d.push_back(rdata); got_rr.push_back(rresp);
                    got_l.push_back(rlast); got_cyc.push_back(cyc);
                    r_seen++;
                    r_hold = 0;
                end else begin
                    r_hold = 1;
                    hr = {rid, rdata, rresp, rlast};
                end
            end else if (r_hold) begin
                chk("rvalid_held", rvalid, 1);
                r_hold = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int id, size, burst, len, a, nb, j, tgt, t;
        reset = 1'b1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
        chk("rst_payload", {bid, bresp, rid, rresp, rdata}, 0);
        @(posedge aclk); #2 reset = 1'b0;
        #1 chk("awready_before_edge", awready, 0);
        @(posedge aclk); #1;
        chk("awready_after_rst", awready, 1);
        chk("arready_after_rst", arready, 1);

        // Preload the whole RAM so the model knows every word.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            prep_w(k, 15);
            do_write(k, k * 64, 15, 2, 1, 0);
        end

        // INCR write/read of A0..A3
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        prep_w(5, 3);
        do_write(5, 'h10, 3, 2, 1, 0);
        chk("t1_bresp", last_bresp, 2'b00);
        chk("t1_bid", last_bid, 4'd5);
        do_read(6, 'h10, 3, 2, 1, 0);
        for (int i = 0; i < 4; i++) chk("t1_rdata", got_d[i], 32'hA0 + 32'(i));
        chk("t1_rlast", {got_l[3], got_l[2], got_l[1], got_l[0]}, 4'b1000);

        // WRAP read order and illegal WRAP length
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_0030 + 32'(4 * i); ws[i] = 4'hF; end
        prep_w(2, 3);
        do_write(2, 'h30, 3, 2, 1, 0);
        do_read(3, 'h38, 3, 2, 2, 0);
        chk("t2_wrap0", got_d[0], 32'h1111_0038);
        chk("t2_wrap1", got_d[1], 32'h1111_003C);
        chk("t2_wrap2", got_d[2], 32'h1111_0030);
        chk("t2_wrap3", got_d[3], 32'h1111_0034);
        do_read(3, 'h38, 2, 2, 2, 0);
        for (int i = 0; i < 3; i++) chk("t2_badwrap_resp", got_rr[i], 2'b10);

        // Strobe merge
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF; prep_w(1, 0);
        do_write(1, 'h20, 0, 2, 1, 0);
        wd[0] = 32'h1122_3344; ws[0] = 4'h5; prep_w(1, 0);
        do_write(1, 'h20, 0, 2, 1, 0);
        do_read(1, 'h20, 0, 2, 1, 1);
        chk("t3_merge", got_d[0], 32'hFF22_FF44);

        // Out of range: write at 0x400 must not alias onto word 0
        wd[0] = 32'hC0FF_EE00; ws[0] = 4'hF; prep_w(4, 0);
        do_write(4, 'h0, 0, 2, 1, 0);
        wd[0] = 32'hDEAD_BEEF; prep_w(4, 0);
        do_write(4, 'h400, 0, 2, 1, 0);
        chk("t4_bresp", last_bresp, 2'b10);
        do_read(4, 'h0, 0, 2, 1, 0);
        chk("t4_word0", got_d[0], 32'hC0FF_EE00);
        do_read(4, 'h3FC, 1, 2, 1, 0);
        chk("t4_resp0", got_rr[0], 2'b00);
        chk("t4_resp1", got_rr[1], 2'b10);
        chk("t4_data1", got_d[1], 32'h0);

        // Backpressure on B and R
        wd[0] = 32'h5555_AAAA; ws[0] = 4'hF; prep_w(9, 0);
        do_write(9, 'h80, 0, 2, 1, 5);
        chk("t5_bid", last_bid, 4'd9);
        do_read(7, 'h10, 3, 2, 1, 2);
        chk("t5_count", got_d.size(), 4);
        for (int i = 0; i < 4; i++) chk("t5_rdata", got_d[i], 32'hA0 + 32'(i));

        // Reset in the middle of a 4-beat read
        do_read(0, 'h100, 0, 2, 1, 0);
        begin
            rbeat_t r;
            for (int i = 0; i < 4; i++) begin
                r.id = 4'd8; r.resp = 2'b00; r.last = (i == 3);
                r.data = {mm['h103 + 4*i], mm['h102 + 4*i], mm['h101 + 4*i], mm['h100 + 4*i]};
                exp_r.push_back(r);
            end
        end
        arid = 4'd8; araddr = 'h100; arlen = 4'd3; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        wait_sig(2, "arready_rst");
        @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
        tgt = r_seen + 1; t = 0;
        while (r_seen != tgt && t < 50) begin @(posedge aclk); #1; t++; end
        if (t >= 50) timeout_fail("t6_beat1");
        rready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_rvalid", rvalid, 0);
        chk("t6_arready", arready, 0);
        exp_r.delete();
        repeat (2) @(posedge aclk);
        #2 reset = 1'b0;
        @(posedge aclk); #1;
        chk("t6_arready_after", arready, 1);
        do_read(8, 'h100, 3, 2, 1, 0);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            id    = $urandom % 16;
            size  = ($urandom % 8 == 0) ? 3 : $urandom % 3;
            burst = ($urandom % 10 == 0) ? 3 : $urandom % 3;
            if (burst == 2) begin
                case ($urandom % 5)
                    0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
                endcase
            end else len = $urandom % 16;
            nb = 1 << size;
            a  = $urandom % 'h440;
            a  = a - (a % nb);
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            prep_w(id, len);
            if ($urandom % 8 == 0) begin j = $urandom % (len + 1); wid_v[j] = (id + 1) % 16; end
            if ($urandom % 8 == 0) begin j = $urandom % (len + 1); wl_v[j] = !wl_v[j]; end
            do_write(id, a, len, size, burst, $urandom % 3);
            do_read((id + 3) % 16, a, len, size, burst, $urandom % 3);
            if ($urandom % 3 == 0) do_read(id, ($urandom % 'h400) & ~3, $urandom % 16, 2, 0, 1);
        end

        repeat (4) @(posedge aclk);
        chk("exp_r_drained", exp_r.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Parametrised AXI3 slave memory model: byte-addressed, word-organised RAM behind full AW/W/B/AR/R channels.
- Serves as the synthesizable DUT-side responder for the AXI master agents, replacing the fixed 32-bit/4-bit-ID signal set with configurable widths and depth.
- Adds FIXED/INCR/WRAP burst address generation, byte strobes, narrow sizes and SLVERR signalling.
- Read and write paths are independent; each accepts one outstanding transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; one of 32, 64, 128.
- ID_W, 4, width of awid/wid/bid/arid/rid.
- MEM_DEPTH, 256, number of DATA_W words; byte capacity BYTES = MEM_DEPTH*DATA_W/8.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- awid in ID_W; awaddr in ADDR_W; awlen in 4; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
- wid in ID_W; wdata in DATA_W; wstrb in DATA_W/8; wlast in 1; wvalid in 1; wready out 1.
- bid out ID_W; bresp out 2; bvalid out 1; bready in 1.
- arid in ID_W; araddr in ADDR_W; arlen in 4; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
- rid out ID_W; rdata out DATA_W; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high, port name reset.
- Reset values: all outputs 0; both FSMs go to IDLE. Memory contents are not cleared.
- awready/arready rise on the first aclk edge after reset deasserts.
- Reset asserted mid-burst aborts the transaction immediately: valids drop asynchronously and no response is issued.
- Handshake: a transfer occurs on a rising aclk edge with valid&ready both high. Outputs are registered.
- Once asserted, bvalid/rvalid and their payloads hold stable until the handshake completes.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture id/addr/len/size/burst, clear beat count and the error flag, set awready=0, wready=1, go W_DATA.
  - W_DATA: each W handshake writes the bytes whose wstrb bit is set into word addr/(DATA_W/8), then advances addr and beat count.
  - The beat with count==awlen ends the burst: wready=0, bvalid=1, bid=captured awid, go W_RESP.
  - W_RESP: on B handshake, bvalid=0, awready=1, go W_IDLE.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture fields, load rdata<=mem[word(araddr)], set rvalid=1, rid=arid, rlast=(arlen==0), go R_DATA.
  - R_DATA: on R handshake with rlast=0, advance addr and load the next word in the same edge. This gives zero-bubble streaming when rready is held high.
  - On R handshake with rlast=1: rvalid=0, arready=1, go R_IDLE.
- Address generation, with bytes=1<<size:
  - FIXED: address unchanged.
  - INCR: addr+bytes.
  - WRAP: W=bytes*(len+1); next=(addr&~(W-1))|((addr+bytes)&(W-1)).
- Error rules give SLVERR (2'b10); OKAY is 2'b00:
  - bytes > DATA_W/8.
  - burst==2'b11.
  - WRAP with len not in {1,3,7,15}.
  - Beat address >= BYTES.
  - Write only: wid!=awid on any beat, or wlast disagreeing with (count==awlen).
- Error effects:
  - Errored write beats are dropped; bresp is the OR-accumulated error over the burst.
  - A burst-level illegal size/burst/len suppresses all writes in that burst.
  - Errored read beats return rdata=0 with rresp=SLVERR per beat. Other beats return OKAY.
- Write/read collision: a same-edge write and fetch to one word returns the old data to the reader.
- Writes and reads to different words are fully concurrent.

Test Plan (DATA_W=32, MEM_DEPTH=256, BYTES=0x400):
1. INCR write: awaddr=0x10, awlen=3, awsize=2, wdata A0,A1,A2,A3, wstrb=F -> one bvalid with bresp=00, bid=awid. INCR read of the same range returns A0..A3 with rlast only on the 4th beat, no bubbles while rready=1.
2. WRAP read: araddr=0x38, arlen=3, arsize=2 after 1 -> beats return words at 0x38, 0x3C, 0x30, 0x34. WRAP with arlen=2 -> all rresp=10.
3. Strobe merge: word 0x20=FFFFFFFF, then write 11223344 with wstrb=0x5 -> readback FF22FF44.
4. Out of range: write awaddr=0x400 len 0 -> bresp=10, memory unchanged. Read araddr=0x3FC arlen=1 INCR -> rresp 00 then 10, second rdata=0.
5. Backpressure: hold bready=0 for 5 cycles -> bvalid/bid/bresp stable and awready=0 throughout. Toggle rready 1,0,1 -> rdata/rlast held during the stall, no beat lost or duplicated.
6. Reset mid-burst: assert reset during beat 2 of a 4-beat read -> rvalid=0 immediately. After release, arready=1 next edge and a new burst completes normally.
